// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake and transmitter-side signals of uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4
);
  logic [NUM_REQUESTERS-1:0]   req_valid;
  logic [NUM_REQUESTERS*8-1:0] req_char;
  logic [NUM_REQUESTERS-1:0]   req_ready;
  logic                        tx_enable;
  logic [7:0]                  tx_char;
  logic                        tx_ready;
  logic [3:0]                  grant_id;
  logic                        busy;

  modport master (
    output req_valid, req_char, tx_ready,
    input  req_ready, tx_enable, tx_char, grant_id, busy
  );

  modport slave (
    input  req_valid, req_char, tx_ready,
    output req_ready, tx_enable, tx_char, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_transmit between NUM_REQUESTERS character sources using
// round-robin arbitration into a one-entry holding register.
// Optional line lock (per-requester lock until newline or timeout): define
// UART_TX_ARB_LINE_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned LOCK_TIMEOUT   = 1024
) (
  input logic              i_clk,
  input logic              i_reset,
  uart_tx_arbiter_if.slave bus
);

  logic                      r_hold_valid;
  logic [7:0]                r_hold_char;
  logic [3:0]                r_last_grant;
  logic [3:0]                r_grant_id;

  logic                      w_tx_enable;
  logic                      w_window;
  logic                      w_found;
  logic                      w_accept;
  logic [3:0]                w_win;
  logic [4:0]                w_idx;
  logic [15:0]               w_valid;
  logic [15:0]               w_lock_mask;
  logic [NUM_REQUESTERS-1:0] w_ready;
  logic [7:0]                w_sel_char;

  // Outputs are forced quiet while reset is asserted, even before the registers clear.
  assign w_tx_enable = r_hold_valid && bus.tx_ready && !i_reset;
  // Holding register can take a character when empty or draining this cycle.
  assign w_window    = !r_hold_valid || w_tx_enable;
  assign w_accept    = w_found && w_window && !i_reset;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_valid = 16'(bus.req_valid) & w_lock_mask;
    w_found = 1'b0;
    w_win   = r_last_grant;
    w_idx   = '0;
    for (int k = 1; k <= int'(NUM_REQUESTERS); k++) begin
      w_idx = {1'b0, r_last_grant} + 5'(k);
      if (w_idx >= 5'(NUM_REQUESTERS)) begin
        w_idx = w_idx - 5'(NUM_REQUESTERS);
      end
      if (!w_found && w_valid[w_idx[3:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[3:0];
      end
    end
  end

  // One-hot ready to the winner, only while the accept window is open.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      w_ready[i] = w_accept && (4'(i) == w_win);
    end
  end

  // Select the winning requester's character.
  always_comb begin
    w_sel_char = '0;
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      if (4'(i) == w_win) begin
        w_sel_char = bus.req_char[i*8 +: 8];
      end
    end
  end

  // Holding register, grant history and issue drain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold_valid <= 1'b0;
      r_hold_char  <= '0;
      r_last_grant <= 4'(NUM_REQUESTERS - 1);
      r_grant_id   <= '0;
    end else begin
      if (w_accept) begin
        r_hold_valid <= 1'b1;
        r_hold_char  <= w_sel_char;
        r_last_grant <= w_win;
        r_grant_id   <= w_win;
      end else if (w_tx_enable) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

  logic            r_locked;
  logic [3:0]      r_lock_id;
  logic [CntW-1:0] r_lock_cnt;

  // While locked only the lock owner is eligible.
  assign w_lock_mask = r_locked ? (16'd1 << r_lock_id) : '1;

  // Lock on any non-newline accept; release on newline or after LOCK_TIMEOUT idle cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_locked   <= 1'b0;
      r_lock_id  <= '0;
      r_lock_cnt <= '0;
    end else if (w_accept) begin
      // Only the owner can be accepted while locked, so this is always "an accept from i".
      r_locked   <= (w_sel_char != 8'h0A);
      r_lock_id  <= w_win;
      r_lock_cnt <= '0;
    end else if (r_locked) begin
      if (r_lock_cnt == CntW'(LOCK_TIMEOUT - 1)) begin
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + CntW'(1);
      end
    end
  end
`else
  assign w_lock_mask = '1;

  // Timeout only matters with line lock; a zero value is simply ignored here.
  if (LOCK_TIMEOUT == 0) begin : g_lock_timeout_unused
  end
`endif

  assign bus.req_ready = w_ready;
  assign bus.tx_enable = w_tx_enable;
  assign bus.tx_char   = i_reset ? 8'h00 : r_hold_char;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = (r_hold_valid && !i_reset) || !bus.tx_ready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed stimulus against a queue-based reference model.
module tb_uart_tx_arbiter;
  localparam int unsigned N      = 4;
  localparam int unsigned LockTo = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQUESTERS(N),
    .LOCK_TIMEOUT  (LockTo)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus state
  logic [7:0]   src_q [N][$];
  bit           rand_mode;
  logic [N-1:0] rv;
  logic [7:0]   rc [N];
  int           frame_len;
  int           tx_busy;
  bit           tx_hold;
  logic [N-1:0] drv_valid;
  logic [N*8-1:0] drv_char;

  // Reference model
  logic [7:0] m_hold [$];
  int         m_last;
  int         m_gid;
  bit         m_locked;
  int         m_lock_id;
  int         m_idle;

  // Observations
  logic [7:0] issued [$];
  int         issue_cyc [$];
  int         acc_cyc [N];
  int         cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_hold.delete();
    m_last    = N - 1;
    m_gid     = 0;
    m_locked  = 0;
    m_lock_id = 0;
    m_idle    = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, then advance model and sources.
  task automatic cycle(input bit rst);
    int           win;
    bit           txen;
    bit           window;
    logic [N-1:0] exp_ready;
    logic [7:0]   ch;
    @(negedge clk);
    reset = rst;
    for (int i = 0; i < N; i++) begin
      if (rand_mode) begin
        drv_valid[i]       = rv[i];
        drv_char[i*8 +: 8] = rc[i];
      end else begin
        drv_valid[i]       = (src_q[i].size() > 0);
        drv_char[i*8 +: 8] = drv_valid[i] ? src_q[i][0] : 8'h00;
      end
    end
    bus.req_valid = drv_valid;
    bus.req_char  = drv_char;
    bus.tx_ready  = (tx_busy == 0) && !tx_hold;
    #1;

    txen   = !rst && (m_hold.size() != 0) && bus.tx_ready;
    window = (m_hold.size() == 0) || txen;
    win    = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (win < 0 && drv_valid[c] && (!m_locked || c == m_lock_id)) win = c;
    end
    exp_ready = '0;
    if (!rst && window && win >= 0) exp_ready[win] = 1'b1;

    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("tx_enable", 32'(bus.tx_enable), 32'(txen));
    check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check("busy", 32'(bus.busy), 32'((!rst && m_hold.size() != 0) || !bus.tx_ready));
    if (rst) check("tx_char_rst", 32'(bus.tx_char), 32'(0));
    else if (txen) check("tx_char", 32'(bus.tx_char), 32'(m_hold[0]));

    if (bus.tx_enable) begin
      issued.push_back(bus.tx_char);
      issue_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] && drv_valid[i]) acc_cyc[i] = cyc;
    end

    // Model state as of the coming rising edge
    if (rst) begin
      model_reset();
      tx_busy = 0;
    end else begin
      if (txen) void'(m_hold.pop_front());
      if (exp_ready != 0) begin
        ch = drv_char[win*8 +: 8];
        m_hold.push_back(ch);
        m_last = win;
        m_gid  = win;
`ifdef UART_TX_ARB_LINE_LOCK_EN
        m_locked  = (ch != 8'h0A);
        m_lock_id = win;
        m_idle    = 0;
      end else if (m_locked) begin
        m_idle++;
        if (m_idle == LockTo) begin
          m_locked = 0;
          m_idle   = 0;
        end
`endif
      end
      if (txen) tx_busy = frame_len;
      else if (tx_busy > 0) tx_busy--;
    end

    // Sources react to the accept they were given
    for (int i = 0; i < N; i++) begin
      if (rand_mode) begin
        if (exp_ready[i] || !rv[i]) begin
          rv[i] = ($urandom_range(0, 2) == 0);
          rc[i] = 8'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          rv[i] = 1'b0;
        end
      end else if (exp_ready[i]) begin
        void'(src_q[i].pop_front());
      end
    end
    cyc++;
  endtask

  task automatic start_scenario();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      acc_cyc[i] = -1000;
    end
    rand_mode = 0;
    rv        = '0;
    tx_hold   = 0;
    tx_busy   = 0;
    frame_len = 0;
    cycle(1);
    issued.delete();
    issue_cyc.delete();
  endtask

  task automatic run_until_issued(input int n, input int budget, input string tag);
    int g;
    g = 0;
    while (issued.size() < n && g < budget) begin
      cycle(0);
      g++;
    end
    check(tag, 32'(issued.size()), 32'(n));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_char  = '0;
    bus.tx_ready  = 1'b1;
    for (int i = 0; i < N; i++) rc[i] = '0;
    repeat (3) @(negedge clk);
    model_reset();

    // Reset state
    start_scenario();
    cycle(1);

    // Single character from requester 2
    start_scenario();
    src_q[2].push_back(8'h41);
    cycle(0);
    cycle(0);
    check("single_gid", 32'(bus.grant_id), 32'd2);
    check("single_cnt", 32'(issued.size()), 32'd1);
    if (issued.size() > 0) check("single_char", 32'(issued[0]), 32'h41);

    // Round-robin with a slow transmitter
    start_scenario();
    frame_len = 20;
    for (int i = 0; i < N; i++) repeat (8) src_q[i].push_back(8'(8'h41 + i));
    run_until_issued(12, 2000, "rr_count");
    for (int k = 0; k < 12 && k < issued.size(); k++)
      check("rr_order", 32'(issued[k]), 32'(8'h41 + (k % N)));

    // Back-to-back stream against a BAUD_DIVIDE=3 frame
    start_scenario();
    frame_len = 30;
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'(k));
    run_until_issued(8, 1000, "b2b_count");
    for (int k = 0; k < issued.size(); k++) begin
      check("b2b_order", 32'(issued[k]), 32'(k));
      if (k > 0) check("b2b_gap", 32'(issue_cyc[k] - issue_cyc[k-1]), 32'(frame_len + 1));
    end

    // Reset while a character is held
    start_scenario();
    tx_hold = 1;
    src_q[0].push_back(8'h55);
    cycle(0);
    cycle(0);
    cycle(1);
    tx_hold = 0;
    repeat (10) cycle(0);
    check("rst_mid_issues", 32'(issued.size()), 32'd0);

    // Randomized traffic with occasional resets
    start_scenario();
    rand_mode = 1;
    for (int t = 0; t < 3000; t++) begin
      frame_len = $urandom_range(0, 4);
      cycle($urandom_range(0, 299) == 0);
    end

    // Idle
    start_scenario();
    src_q[1].push_back(8'h31);
    repeat (3) cycle(0);
    issued.delete();
    repeat (100) cycle(0);
    check("idle_issues", 32'(issued.size()), 32'd0);
    check("idle_gid", 32'(bus.grant_id), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);

`ifdef UART_TX_ARB_LINE_LOCK_EN
    // Line lock: "hi\n" from requester 1 completes before requester 3
    start_scenario();
    src_q[1].push_back(8'h68);
    src_q[1].push_back(8'h69);
    src_q[1].push_back(8'h0A);
    src_q[3].push_back(8'h5A);
    run_until_issued(4, 200, "lock_count");
    if (issued.size() == 4) begin
      check("lock_c0", 32'(issued[0]), 32'h68);
      check("lock_c1", 32'(issued[1]), 32'h69);
      check("lock_c2", 32'(issued[2]), 32'h0A);
      check("lock_c3", 32'(issued[3]), 32'h5A);
    end

    // Line lock timeout: requester 1 stalls after 'h'
    start_scenario();
    src_q[1].push_back(8'h68);
    src_q[3].push_back(8'h5A);
    repeat (30) cycle(0);
    check("lock_timeout", 32'(acc_cyc[3] - acc_cyc[1]), 32'(LockTo + 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmit instance between NUM_REQUESTERS independent character sources, e.g. a debug monitor, a boot loader and CPU console output.
- Each requester presents characters on a valid/ready handshake.
- A round-robin arbiter picks the next requester and loads its character into a one-entry holding register.
- The block drives tx_enable/tx_char whenever the transmitter reports tx_ready.
- Sits between the requester blocks and uart_transmit on the FPGA top level.

Parameters:
- NUM_REQUESTERS, 4, number of requesters; legal range 1..16.
- LOCK_TIMEOUT, 1024, idle cycles after which a line lock is released. Used only with the optional feature; legal range 1..2^20.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQUESTERS  bit i: requester i has a character.
- req_char  in  NUM_REQUESTERS*8  requester i character in bits [8i+7:8i].
- req_ready  out  NUM_REQUESTERS  one-hot or zero; bit i: requester i's character is accepted this cycle.
- tx_enable  out  1  start transmission of tx_char; connects to uart_transmit.
- tx_char  out  8  character to transmit.
- tx_ready  in  1  transmitter idle; from uart_transmit.
- grant_id  out  4  index of the last accepted requester.
- busy  out  1  holding register full or tx_ready low.

Behaviour:
- Reset, sampled on the rising edge of clk:
  - hold_valid=0, hold_char=0, last_grant=NUM_REQUESTERS-1, grant_id=0, lock state cleared.
  - Outputs during and after reset: tx_enable=0, req_ready=0, tx_char=0, busy=!tx_ready.
- Issue:
  - tx_enable = hold_valid && tx_ready (combinational); tx_char = hold_char.
  - On a cycle with tx_enable=1, hold_valid clears at the clock edge unless a new character is accepted in the same cycle.
- Accept window: the holding register can accept when !hold_valid || tx_enable, i.e. empty or draining this cycle.
- Arbitration, combinational:
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_REQUESTERS.
  - The first i with req_valid[i]=1 wins.
  - If the accept window is open, req_ready[i]=1 and all other bits are 0.
- Accept:
  - On the edge where req_valid[i] && req_ready[i]: hold_char <= req_char[i], hold_valid <= 1, last_grant <= i, grant_id <= i.
- Latency:
  - A character accepted in cycle t appears with tx_enable=1 in cycle t+1 if tx_ready=1.
  - Otherwise it waits; hold_char is held stable until issued.
- Back-to-back: while a character shifts out, the next character is pre-accepted. It issues in the first cycle tx_ready returns high, so there are no idle bit-times between characters.
- Requester contract:
  - req_char[i] is stable while req_valid[i]=1 and req_ready[i]=0.
  - Dropping req_valid before ready is legal; the character is simply not taken.
- No requesters valid: req_ready=0 and last_grant is unchanged.
- NUM_REQUESTERS=1: arbitration degenerates to pass-through and grant_id is always 0.
- Reset mid-operation: the held character is discarded and not transmitted. The transmitter's own reset handles any frame in flight.

Optional Feature:
- Macro: UART_TX_ARB_LINE_LOCK_EN.
- When defined, line lock is active:
  - After accepting a character other than 8'h0A from requester i, the arbiter locks to i.
  - While locked, only requester i may be granted; other requesters see req_ready=0.
  - The lock releases on the accept of 8'h0A from i.
  - The lock also releases after LOCK_TIMEOUT consecutive cycles without an accept from i; the counter resets on each accept from i.
  - On release, normal round-robin resumes from i+1.
- When not defined: no lock state, no timeout counter, pure per-character round-robin.

Test Plan:
- Single character: reset, hold tx_ready=1, req_valid[2]=1, req_char[2]=8'h41 for one cycle → req_ready=4'b0100 that cycle; next cycle tx_enable=1, tx_char=8'h41, grant_id=2.
- Round-robin: all four requesters continuously valid with chars 'A','B','C','D', using a transmitter model that drops tx_ready for 20 cycles per character → transmitted order A,B,C,D,A,B,... and each req_ready asserts once per four issues.
- Back-to-back: requester 0 streams 8'h00..8'h07 while tx_ready toggles as uart_transmit with BAUD_DIVIDE=3 → the next tx_enable occurs in the first cycle tx_ready=1 after each frame, with zero gap cycles and correct order.
- Reset mid-operation: accept 8'h55 while tx_ready=0, assert reset for one cycle, then release tx_ready=1 → tx_enable never asserts for 8'h55 and req_ready=0 during reset.
- Line lock (UART_TX_ARB_LINE_LOCK_EN, LOCK_TIMEOUT=8):
  - Requester 1 sends "hi\n" while requester 3 is continuously valid → output is 'h','i',8'h0A and then requester 3's character.
  - Repeat with requester 1 stalling after 'h' → requester 3 is granted after exactly 8 idle cycles.
- Idle: no req_valid for 100 cycles → tx_enable=0, req_ready=0, grant_id unchanged, busy=0.
